// File: rtl/mod_n_count_fsm.sv
// -----------------------------------------------------------------------------
// mod_n_count_fsm
//
// Modulo-MOD_N event counter. An "event" is either the In1 level
// (EDGE_MODE=0) or a rising edge of In1 (EDGE_MODE=1). Each enabled event
// advances Count by one. Count wraps from MOD_N-1 back to 0, and Wrap
// pulses for one cycle when that happens. Out1 flags a count window.
//
// Parameters
//   MOD_N     : counter modulus, 2..256
//   OUT_LO    : lowest count at which Out1 is high
//   OUT_HI    : highest count at which Out1 is high
//               (0 <= OUT_LO <= OUT_HI <= MOD_N-1)
//   EDGE_MODE : 0 = count the In1 level, 1 = count rising edges of In1
//
// Ports
//   CLK     in   clock, rising edge
//   RST     in   asynchronous active-high reset
//   In1     in   event input
//   En      in   count enable
//   Clr     in   synchronous clear (has priority over counting)
//   Out1    out  registered, high while OUT_LO <= Count <= OUT_HI
//   Count   out  current count, CW bits
//   Wrap    out  registered one-cycle pulse after an increment MOD_N-1 -> 0
//   WrapCnt out  saturating 8-bit wrap counter; present only when the
//                macro MOD_N_COUNT_FSM_WRAP_CNT_EN is defined
//
// Valid/ready: this block has no handshake. Every output is valid in every
// cycle, and In1/En/Clr are sampled on every rising CLK edge.
// -----------------------------------------------------------------------------
module mod_n_count_fsm #(
    parameter int MOD_N     = 3,
    parameter int OUT_LO    = 2,
    parameter int OUT_HI    = 2,
    parameter int EDGE_MODE = 0,
    localparam int CW       = (MOD_N > 2) ? $clog2(MOD_N) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          In1,
    input  logic          En,
    input  logic          Clr,
    output logic          Out1,
    output logic [CW-1:0] Count,
    output logic          Wrap
`ifdef MOD_N_COUNT_FSM_WRAP_CNT_EN
    ,
    output logic [7:0]    WrapCnt
`endif
);

    logic [CW-1:0] count_q, count_d;
    logic          out1_q, out1_d;
    logic          wrap_q, wrap_d;
    logic          in_q;
    logic          event_w;

    // in_q resets to 1 so that In1 held high across reset release is not
    // seen as a rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_q <= 1'b1;
        end else begin
            in_q <= In1;
        end
    end

    always_comb begin
        event_w = (EDGE_MODE != 0) ? (In1 & ~in_q) : In1;
    end

    // Next count, Out1 and Wrap. Out1 is decoded from count_d so that it
    // lines up with the Count loaded on the same edge.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (Clr) begin
            count_d = '0;
        end else if (int'(count_q) >= MOD_N) begin
            // Unreachable value: recover to 0 without signalling a wrap.
            count_d = '0;
        end else if (En && event_w) begin
            if (int'(count_q) == MOD_N - 1) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
        out1_d = (int'(count_d) >= OUT_LO) && (int'(count_d) <= OUT_HI);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            out1_q  <= (OUT_LO == 0);
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            out1_q  <= out1_d;
        end
    end

    assign Count = count_q;
    assign Wrap  = wrap_q;
    assign Out1  = out1_q;

`ifdef MOD_N_COUNT_FSM_WRAP_CNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // Counts alongside wrap_d so WrapCnt steps on the same edge Wrap rises.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (Clr) begin
            wrap_cnt_d = 8'd0;
        end else if (wrap_d && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign WrapCnt = wrap_cnt_q;
`endif

endmodule
